// File: rtl/colorizer_pal.sv
// rtl/colorizer_pal.sv - two-stage pixel colorizer with double-buffered CPU palette
// Optional macro BLINK_EN: icon layer 0 blinks with a half-period of BLINK_FRAMES frames.
module colorizer_pal #(
    parameter int COLOR_W      = 12,
    parameter int WORLD_W      = 2,
    parameter int NUM_ICONS    = 2,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WORLD_W-1:0]             world_in,
    input  logic [NUM_ICONS*COLOR_W-1:0]   icon_in,
    input  logic                           enable_video,
    input  logic                           frame_tick,
    input  logic                           pal_wr_en,
    input  logic [WORLD_W-1:0]             pal_wr_addr,
    input  logic [COLOR_W-1:0]             pal_wr_data,
    output logic                           pal_wr_ack,
    output logic [COLOR_W-1:0]             draw_color,
    output logic                           draw_valid
);

    localparam int DEPTH = 2**WORLD_W;
    localparam int THIRD = COLOR_W / 3;

    // Colour layout is {red, grn, blu}, each THIRD bits wide.
    function automatic logic [COLOR_W-1:0] f_reset_color(input int idx);
        logic [COLOR_W-1:0] v;
        v = '0;
        case (idx)
            0:       v = '1;
            2:       v[THIRD +: THIRD] = '1;
            3:       v[2*THIRD +: THIRD] = '1;
            default: v = '0;
        endcase
        return v;
    endfunction

    logic [COLOR_W-1:0]           r_shadow [DEPTH];
    logic [COLOR_W-1:0]           r_active [DEPTH];
    logic                         r_wr_ack;

    logic [WORLD_W-1:0]           r_s1_world;
    logic [NUM_ICONS*COLOR_W-1:0] r_s1_icon;
    logic                         r_s1_en;

    logic [COLOR_W-1:0]           r_draw_color;
    logic                         r_draw_valid;

    logic [COLOR_W-1:0]           w_color;
    logic [COLOR_W-1:0]           w_icon;
    logic                         w_hit;
    logic                         w_blink_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_shadow[i] <= f_reset_color(i);
            end
            r_wr_ack <= 1'b0;
        end else begin
            if (pal_wr_en) begin
                r_shadow[pal_wr_addr] <= pal_wr_data;
            end
            r_wr_ack <= pal_wr_en;
        end
    end

    // Non-blocking copy: a write on the same edge as frame_tick is not committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_active[i] <= f_reset_color(i);
            end
        end else if (frame_tick) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

`ifdef BLINK_EN
    localparam int CNT_W = $clog2(2*BLINK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_FRAMES);

    logic [CNT_W-1:0] r_frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (frame_tick) begin
            r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + 1'b1;
        end
    end

    assign w_blink_off = (r_frame_cnt >= CNT_HALF);
`else
    assign w_blink_off = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_world <= '0;
            r_s1_icon  <= '0;
            r_s1_en    <= 1'b0;
        end else begin
            r_s1_world <= world_in;
            r_s1_icon  <= icon_in;
            r_s1_en    <= enable_video;
        end
    end

    // Lowest-index opaque icon wins; otherwise the world code picks a palette entry.
    always_comb begin
        w_color = '0;
        w_icon  = '0;
        w_hit   = 1'b0;
        if (r_s1_en) begin
            for (int k = 0; k < NUM_ICONS; k++) begin
                w_icon = r_s1_icon[k*COLOR_W +: COLOR_W];
                if (!w_hit && (w_icon != '0) && !((k == 0) && w_blink_off)) begin
                    w_color = w_icon;
                    w_hit   = 1'b1;
                end
            end
            if (!w_hit) begin
                w_color = r_active[r_s1_world];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_draw_color <= '0;
            r_draw_valid <= 1'b0;
        end else begin
            r_draw_color <= w_color;
            r_draw_valid <= r_s1_en;
        end
    end

    assign draw_color = r_draw_color;
    assign draw_valid = r_draw_valid;
    assign pal_wr_ack = r_wr_ack;

endmodule

// File: tb/tb_colorizer_pal.sv
// tb/tb_colorizer_pal.sv - self-checking bench for colorizer_pal against a cycle-level reference model
module tb_colorizer_pal;

    localparam int CW    = 12;
    localparam int WW    = 2;
    localparam int NI    = 2;
    localparam int BF    = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WW-1:0]    world_in;
    logic [NI*CW-1:0] icon_in;
    logic             enable_video;
    logic             frame_tick;
    logic             pal_wr_en;
    logic [WW-1:0]    pal_wr_addr;
    logic [CW-1:0]    pal_wr_data;
    logic             pal_wr_ack;
    logic [CW-1:0]    draw_color;
    logic             draw_valid;

    colorizer_pal #(
        .COLOR_W(CW), .WORLD_W(WW), .NUM_ICONS(NI), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .world_in(world_in), .icon_in(icon_in),
        .enable_video(enable_video), .frame_tick(frame_tick),
        .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data),
        .pal_wr_ack(pal_wr_ack), .draw_color(draw_color), .draw_valid(draw_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic             en;
        logic [WW-1:0]    world;
        logic [NI*CW-1:0] icons;
    } pix_t;

    logic [CW-1:0] m_shadow [DEPTH];
    logic [CW-1:0] m_active [DEPTH];
    int            m_frames;
    pix_t          m_pipe [$];
    logic [CW-1:0] e_color;
    logic          e_valid;
    logic          e_ack;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] colour_of(input pix_t p);
        logic [CW-1:0] ic;
        if (!p.en) return '0;
        for (int k = 0; k < NI; k++) begin
            ic = p.icons[k*CW +: CW];
`ifdef BLINK_EN
            if (k == 0 && (m_frames % (2*BF)) >= BF) continue;
`endif
            if (ic != '0) return ic;
        end
        return m_active[p.world];
    endfunction

    task automatic model_reset();
        m_shadow = '{12'hFFF, 12'h000, 12'h0F0, 12'hF00};
        m_active = '{12'hFFF, 12'h000, 12'h0F0, 12'hF00};
        m_frames = 0;
        m_pipe.delete();
        m_pipe.push_back(pix_t'(0));
        e_color = '0;
        e_valid = 1'b0;
        e_ack   = 1'b0;
    endtask

    // One clock: advance the model with the inputs seen at this edge, then compare.
    task automatic tick();
        pix_t old;
        pix_t cur;
        @(posedge clk);
        old = m_pipe.pop_front();
        e_color = colour_of(old);
        e_valid = old.en;
        cur.en = enable_video;
        cur.world = world_in;
        cur.icons = icon_in;
        m_pipe.push_back(cur);
        if (frame_tick) begin
            m_active = m_shadow;
            m_frames++;
        end
        if (pal_wr_en) m_shadow[pal_wr_addr] = pal_wr_data;
        e_ack = pal_wr_en;
        #1;
        check_eq("model_color", draw_color, e_color);
        check_eq("model_valid", draw_valid, e_valid);
        check_eq("model_ack", pal_wr_ack, e_ack);
    endtask

    task automatic set_px(input logic en, input logic [WW-1:0] w, input logic [CW-1:0] ic0, input logic [CW-1:0] ic1);
        enable_video = en;
        world_in     = w;
        icon_in      = {ic1, ic0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_color", draw_color, 0);
        check_eq("rst_valid", draw_valid, 0);
        check_eq("rst_ack", pal_wr_ack, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_px(1'b0, '0, '0, '0);
        frame_tick = 1'b0;
        pal_wr_en = 1'b0;
        pal_wr_addr = '0;
        pal_wr_data = '0;
        model_reset();
        do_reset();

        set_px(1'b1, 2'd2, '0, '0);
        tick();
        check_eq("lat_first_zero", draw_color, 0);
        tick();
        check_eq("world2_green", draw_color, 12'h0F0);
        check_eq("world2_valid", draw_valid, 1);
        repeat (2) tick();

        set_px(1'b1, 2'd0, 12'h00F, 12'hABC);
        repeat (2) tick();
        check_eq("icon0_prio", draw_color, 12'h00F);
        set_px(1'b1, 2'd0, 12'h000, 12'hABC);
        repeat (2) tick();
        check_eq("icon1_show", draw_color, 12'hABC);
        set_px(1'b1, 2'd0, 12'h000, 12'h000);
        repeat (2) tick();
        check_eq("world0_white", draw_color, 12'hFFF);

        set_px(1'b1, 2'd1, '0, '0);
        pal_wr_en = 1'b1; pal_wr_addr = 2'd1; pal_wr_data = 12'h123;
        tick();
        check_eq("wr_ack", pal_wr_ack, 1);
        pal_wr_en = 1'b0;
        repeat (3) tick();
        check_eq("shadow_hidden", draw_color, 12'h000);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (2) tick();
        check_eq("commit_visible", draw_color, 12'h123);

        set_px(1'b1, 2'd0, '0, '0);
        pal_wr_en = 1'b1; pal_wr_addr = 2'd0; pal_wr_data = 12'h456;
        frame_tick = 1'b1;
        tick();
        pal_wr_en = 1'b0; frame_tick = 1'b0;
        repeat (3) tick();
        check_eq("same_edge_old", draw_color, 12'hFFF);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (2) tick();
        check_eq("second_commit", draw_color, 12'h456);

        set_px(1'b0, 2'd0, 12'hF00, '0);
        repeat (2) tick();
        check_eq("blank_color", draw_color, 0);
        check_eq("blank_valid", draw_valid, 0);

        set_px(1'b1, 2'd3, '0, '0);
        pal_wr_en = 1'b1; pal_wr_addr = 2'd2; pal_wr_data = 12'h777;
        repeat (2) tick();
        pal_wr_en = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_eq("midrst_color", draw_color, 0);
        check_eq("midrst_valid", draw_valid, 0);
        check_eq("midrst_ack", pal_wr_ack, 0);
        do_reset();
        set_px(1'b1, 2'd1, '0, '0);
        repeat (2) tick();
        check_eq("rst_pal1", draw_color, 12'h000);
        set_px(1'b1, 2'd0, '0, '0);
        repeat (2) tick();
        check_eq("rst_pal0", draw_color, 12'hFFF);

`ifdef BLINK_EN
        do_reset();
        set_px(1'b1, 2'd0, 12'hF00, '0);
        for (int f = 0; f < 6; f++) begin
            repeat (3) tick();
            check_eq("blink", draw_color, ((f % 4) < 2) ? 12'hF00 : 12'hFFF);
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
        end
`endif

        for (int n = 0; n < 400; n++) begin
            enable_video = ($urandom_range(0, 4) != 0);
            world_in     = WW'($urandom_range(0, DEPTH-1));
            icon_in[0 +: CW]  = ($urandom_range(0, 1) != 0) ? CW'($urandom) : '0;
            icon_in[CW +: CW] = ($urandom_range(0, 1) != 0) ? CW'($urandom) : '0;
            frame_tick   = ($urandom_range(0, 7) == 0);
            pal_wr_en    = ($urandom_range(0, 3) == 0);
            pal_wr_addr  = WW'($urandom_range(0, DEPTH-1));
            pal_wr_data  = CW'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/colorizer_pal.md
Name: colorizer_pal

Overview:
Pixel colour stage between the world-map/icon readers and the VGA output pins. It generalises the fixed-colour colorizer in three ways:
- parametrised colour depth, world code width and number of icon layers;
- a CPU-programmable palette, double-buffered so updates take effect only at frame boundaries;
- a fixed two-stage registered pipeline with a matching valid output.

Parameters:
COLOR_W, 12, bits per output colour {red,grn,blu}; must be a multiple of 3.
WORLD_W, 2, bits of world code; palette depth is 2**WORLD_W.
NUM_ICONS, 2, number of icon layers; icon 0 has highest priority.
BLINK_FRAMES, 16, half-period of icon 0 blink in frames (used only with BLINK_EN).

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
world_in  input  WORLD_W  world map code for current pixel
icon_in  input  NUM_ICONS*COLOR_W  icon colours; layer k occupies bits [k*COLOR_W +: COLOR_W]; value 0 = transparent
enable_video  input  1  pixel is in visible region
frame_tick  input  1  one-cycle pulse at start of vertical blank
pal_wr_en  input  1  palette write request
pal_wr_addr  input  WORLD_W  palette entry to write
pal_wr_data  input  COLOR_W  colour to write
pal_wr_ack  output  1  one-cycle pulse acknowledging an accepted write
draw_color  output  COLOR_W  registered pixel colour
draw_valid  output  1  enable_video delayed to align with draw_color

Behaviour:
- Reset (async assert, sync release): draw_color=0, draw_valid=0, pal_wr_ack=0, all pipeline registers 0.
- Reset palette contents, in both shadow and active copies:
  - entry0 = all ones (white), entry1 = 0 (black);
  - entry2 = green, i.e. middle third of bits all ones;
  - entry3 = red, i.e. top third all ones;
  - all entries above 3 = 0.
- If WORLD_W=1, only entries 0 and 1 exist.
- Pipeline stage 1: register world_in, icon_in and enable_video.
- Pipeline stage 2: compute and register the colour from the stage-1 values:
  - stage-1 enable=0 -> 0;
  - else the lowest-index icon layer with a nonzero value -> that icon colour;
  - else active_palette[world].
- draw_valid = stage-1 enable. Latency is exactly 2 clocks from inputs to draw_color/draw_valid; the pipeline accepts a new pixel every cycle with no stalls.
- Palette writes:
  - pal_wr_en sampled every cycle; each asserted cycle is accepted.
  - An accepted write updates shadow[pal_wr_addr] at that clock edge.
  - pal_wr_ack=1 on the following cycle. Back-to-back writes give back-to-back acks.
- Commit: on a cycle where frame_tick=1, active palette <= shadow palette (all entries in one edge). The active palette never changes at any other time.
- Write and frame_tick in the same cycle: the commit copies shadow as it was before that edge. The write lands in shadow only and becomes visible after the next frame_tick.
- frame_tick while enable_video=1 is not checked; the commit still happens and may affect the visible frame.
- Reset mid-frame: pipeline and palettes return to their reset values immediately; any in-flight ack is dropped.

Optional Feature:
Macro BLINK_EN.
- Defined:
  - A frame counter of width clog2(2*BLINK_FRAMES) increments on each frame_tick and wraps from 2*BLINK_FRAMES-1 to 0. Reset value is 0.
  - While counter >= BLINK_FRAMES, icon layer 0 is treated as transparent in stage 2; lower-priority layers and the palette show through.
  - The counter update and the blink decision use the same frame_tick edge as the palette commit.
- Not defined: no counter is built and icon 0 is always honoured.

Test Plan:
- Reset then enable_video=1, world_in=2, icons=0 for 4 cycles -> draw_color=12'h0F0 starting 2 cycles after the inputs, draw_valid=1 aligned with it.
- icon_in layer0=12'h00F, layer1=12'hABC, world_in=0 -> 12'h00F. Then layer0=0 -> 12'hABC. Then both 0 -> 12'hFFF.
- pal_wr_en with addr=1, data=12'h123 -> pal_wr_ack=1 next cycle. world 1 still draws 12'h000 until frame_tick pulses, then 12'h123 from 2 cycles after the tick.
- pal_wr_en addr=0 data=12'h456 in the same cycle as frame_tick -> world 0 stays 12'hFFF; after a second frame_tick it draws 12'h456.
- enable_video=0 with icon layer0=12'hF00 -> draw_color=0, draw_valid=0. Assert reset mid-stream -> all outputs 0 immediately, and palette entry1 reads 12'h000 after release.
- BLINK_EN, BLINK_FRAMES=2, icon layer0=12'hF00, world 0 -> frame_tick count 0,1 shows 12'hF00; count 2,3 shows 12'hFFF; count wraps to 0 and shows 12'hF00 again.
